// File: rtl/lfsr_pkg.sv
// lfsr_pkg -- shared constants, tap table and feedback function for lfsr.
//   MIN_WIDTH / MAX_WIDTH : legal register width range
//   tap_mask(width)       : 16-bit mask, bit (n-1) set for 1-indexed tap n
//   xnor_feedback(s, m)   : XNOR reduction of the masked state bits
package lfsr_pkg;

  localparam int MIN_WIDTH = 3;
  localparam int MAX_WIDTH = 16;

  function automatic logic [MAX_WIDTH-1:0] tap_mask(input int width);
    logic [MAX_WIDTH-1:0] m;
    case (width)
      3:       m = 16'h0006;  // {3,2}
      4:       m = 16'h000C;  // {4,3}
      5:       m = 16'h0014;  // {5,3}
      6:       m = 16'h0030;  // {6,5}
      7:       m = 16'h0060;  // {7,6}
      8:       m = 16'h00B8;  // {8,6,5,4}
      9:       m = 16'h0110;  // {9,5}
      10:      m = 16'h0240;  // {10,7}
      11:      m = 16'h0500;  // {11,9}
      12:      m = 16'h0829;  // {12,6,4,1}
      13:      m = 16'h100D;  // {13,4,3,1}
      14:      m = 16'h2015;  // {14,5,3,1}
      15:      m = 16'h6000;  // {15,14}
      16:      m = 16'hD008;  // {16,15,13,4}
      default: m = '0;
    endcase
    return m;
  endfunction

  // Every tap set has an even number of taps, so all-ones maps to
  // feedback 1 and is therefore a fixed point of the XNOR shift.
  function automatic logic xnor_feedback(input logic [MAX_WIDTH-1:0] state,
                                         input logic [MAX_WIDTH-1:0] mask);
    return ~^(state & mask);
  endfunction

endpackage

// File: rtl/lfsr_feedback.sv
// lfsr_feedback -- combinational XNOR feedback for a WIDTH-bit Fibonacci LFSR.
//   WIDTH   : register width (3..16)
//   state_i : current LFSR state
//   fb_o    : feedback bit shifted into the LSB on the next edge
module lfsr_feedback
  import lfsr_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] state_i,
  output logic             fb_o
);

  localparam logic [MAX_WIDTH-1:0] MASK = tap_mask(WIDTH);

  logic [MAX_WIDTH-1:0] state_ext;

  // Zero-extend so the package function can work on a fixed width; the
  // mask never selects bits above WIDTH-1.
  always_comb begin
    state_ext = '0;
    state_ext[WIDTH-1:0] = state_i;
  end

  assign fb_o = xnor_feedback(state_ext, MASK);

endmodule

// File: rtl/lfsr.sv
// lfsr -- free-running maximal-length Fibonacci XNOR LFSR (shifts toward MSB).
//   WIDTH : register width, 3..16
//   SEED  : reset / lockup-recovery state (must not be all-ones)
//   clk   : clock, rising edge
//   reset : asynchronous active-high reset, loads SEED
//   Q     : current state, straight from the state register
//   wrap  : registered pulse, high for the cycle Q has just shifted into SEED
// Optional macro LFSR_LOCKUP_RECOVER_EN: an all-ones state reloads SEED on
// the next edge (without wrap) instead of locking up.
module lfsr
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 3,
  parameter logic [WIDTH-1:0] SEED  = '0
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] Q,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

  if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("lfsr: WIDTH %0d outside legal range 3..16", WIDTH);
  end
  if (SEED == ALL_ONES) begin : g_bad_seed
    $error("lfsr: SEED must not be the all-ones lockup state");
  end

  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q, wrap_d;
  logic             fb;

  lfsr_feedback #(
    .WIDTH(WIDTH)
  ) u_feedback (
    .state_i(q_q),
    .fb_o   (fb)
  );

  always_comb begin
    q_d    = {q_q[WIDTH-2:0], fb};
    wrap_d = (q_d == SEED);
`ifdef LFSR_LOCKUP_RECOVER_EN
    // Recovery reloads SEED but is not a sequence restart.
    if (q_q == ALL_ONES) begin
      q_d    = SEED;
      wrap_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q    <= SEED;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
    end
  end

  assign Q    = q_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_lfsr.sv
module tb_lfsr;

  logic       clk;
  logic       reset;
  logic [2:0] q3;
  logic       wrap3;
  logic       reset8;
  logic [7:0] q8;
  logic       wrap8;

  int n_cmp;
  int n_bad;

  lfsr #(.WIDTH(3), .SEED(3'b000)) dut (
    .clk  (clk),
    .reset(reset),
    .Q    (q3),
    .wrap (wrap3)
  );

  lfsr #(.WIDTH(8), .SEED(8'h01)) dut8 (
    .clk  (clk),
    .reset(reset8),
    .Q    (q8),
    .wrap (wrap8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [2:0] exp_q;
    logic       exp_wrap;
  } vec_t;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic edge_sample();
    @(posedge clk);
    @(negedge clk);
  endtask

  vec_t vecs[12];
  bit   seen[256];
  int   steps;
  bit   dup;
  bit   saw_ff;
  bit   wrap_early;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset  = 1'b1;
    reset8 = 1'b1;

    vecs[0]  = '{1'b1, 3'b000, 1'b0};
    vecs[1]  = '{1'b1, 3'b000, 1'b0};
    vecs[2]  = '{1'b0, 3'b001, 1'b0};
    vecs[3]  = '{1'b0, 3'b011, 1'b0};
    vecs[4]  = '{1'b0, 3'b110, 1'b0};
    vecs[5]  = '{1'b0, 3'b101, 1'b0};
    vecs[6]  = '{1'b0, 3'b010, 1'b0};
    vecs[7]  = '{1'b0, 3'b100, 1'b0};
    vecs[8]  = '{1'b0, 3'b000, 1'b1};
    vecs[9]  = '{1'b0, 3'b001, 1'b0};
    vecs[10] = '{1'b0, 3'b011, 1'b0};
    vecs[11] = '{1'b0, 3'b110, 1'b0};

    // Asynchronous reset takes effect before any clock edge.
    #1;
    check("async_reset_q", 16'(q3), 16'h0);
    check("async_reset_wrap", 16'(wrap3), 16'h0);

    for (int i = 0; i < 12; i++) begin
      reset = vecs[i].rst;
      edge_sample();
      check($sformatf("vec%0d_q", i), 16'(q3), 16'(vecs[i].exp_q));
      check($sformatf("vec%0d_wrap", i), 16'(wrap3), 16'(vecs[i].exp_wrap));
    end

    // Mid-sequence reset at Q=110, between edges.
    #2;
    reset = 1'b1;
    #1;
    check("midreset_immediate_q", 16'(q3), 16'h0);
    check("midreset_immediate_wrap", 16'(wrap3), 16'h0);
    for (int i = 0; i < 2; i++) begin
      edge_sample();
      check($sformatf("midreset_hold%0d_q", i), 16'(q3), 16'h0);
      check($sformatf("midreset_hold%0d_wrap", i), 16'(wrap3), 16'h0);
    end
    reset = 1'b0;
    edge_sample();
    check("after_release_q", 16'(q3), 16'h1);
    check("after_release_wrap", 16'(wrap3), 16'h0);

    // Lockup: force the state register to all-ones between edges.
    force dut.q_q = 3'b111;
    #1;
    release dut.q_q;
    #1;
    check("lockup_forced_q", 16'(q3), 16'h7);
`ifdef LFSR_LOCKUP_RECOVER_EN
    edge_sample();
    check("recover_q", 16'(q3), 16'h0);
    check("recover_wrap", 16'(wrap3), 16'h0);
    edge_sample();
    check("recover_next_q", 16'(q3), 16'h1);
`else
    for (int i = 0; i < 4; i++) begin
      edge_sample();
      check($sformatf("lockup_hold%0d_q", i), 16'(q3), 16'h7);
      check($sformatf("lockup_hold%0d_wrap", i), 16'(wrap3), 16'h0);
    end
`endif
    reset = 1'b1;
    #1;
    check("lockup_reset_q", 16'(q3), 16'h0);

    // WIDTH=8 period: first return to SEED after exactly 255 edges.
    for (int i = 0; i < 256; i++) seen[i] = 1'b0;
    seen[8'h01] = 1'b1;
    steps = 0;
    dup = 1'b0;
    saw_ff = 1'b0;
    wrap_early = 1'b0;
    edge_sample();
    reset8 = 1'b0;
    do begin
      edge_sample();
      steps++;
      if (q8 == 8'hFF) saw_ff = 1'b1;
      if (q8 != 8'h01) begin
        if (seen[q8]) dup = 1'b1;
        seen[q8] = 1'b1;
        if (wrap8) wrap_early = 1'b1;
      end
    end while (q8 != 8'h01 && steps < 300);
    check("w8_period", 16'(steps), 16'd255);
    check("w8_wrap_at_return", 16'(wrap8), 16'h1);
    check("w8_distinct", 16'(dup), 16'h0);
    check("w8_no_ff", 16'(saw_ff), 16'h0);
    check("w8_no_early_wrap", 16'(wrap_early), 16'h0);
    edge_sample();
    check("w8_wrap_one_cycle", 16'(wrap8), 16'h0);
    check("w8_after_return_q", 16'(q8), 16'h03);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lfsr.md
LFSR -- requirements
Module: lfsr

Interface
REQ-001 SHALL expose parameter WIDTH, default 3: register width, legal range 3..16.
REQ-002 SHALL expose parameter SEED, default 0: reset/lockup-recovery state, WIDTH bits.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port Q, output, WIDTH bits: current LFSR state, driven directly from the state register.
REQ-006 SHALL have port wrap, output, 1 bit: registered one-cycle pulse marking sequence restart.
REQ-007 SHALL have no other ports; the block free-runs whenever reset is low.

Function
REQ-008 SHALL implement a Fibonacci LFSR shifting toward MSB: next Q = {Q[WIDTH-2:0], fb}.
REQ-009 SHALL compute fb as XNOR of the tap bits for WIDTH (1-indexed tap n = Q[n-1]).
- XNOR is the inversion of XOR-reduction over the tap bits.
REQ-010 SHALL use the tap sets 3:{3,2} 4:{4,3} 5:{5,3} 6:{6,5} 7:{7,6} 8:{8,6,5,4} 9:{9,5} 10:{10,7} 11:{11,9} 12:{12,6,4,1} 13:{13,4,3,1} 14:{14,5,3,1} 15:{15,14} 16:{16,15,13,4}.
REQ-011 SHALL advance exactly one state per rising clk edge while reset is low, with no enable or stall.
REQ-012 SHALL have a maximal period of 2^WIDTH-1; the all-ones state is the lockup state and is never reached from a legal state.
REQ-013 For WIDTH=3, SEED=0, SHALL produce this order from reset: 000, 001, 011, 110, 101, 010, 100, 000, ...
REQ-014 SHALL assert wrap for exactly the one cycle in which Q has just transitioned into SEED by a normal shift.
- Entry into SEED via reset SHALL NOT assert wrap.
- Entry into SEED via lockup recovery SHALL NOT assert wrap.
REQ-015 SHALL raise an elaboration-time error if WIDTH is outside 3..16.
REQ-016 SHALL raise an elaboration-time error if SEED equals all-ones.

Reset
REQ-017 When reset is high, SHALL immediately (asynchronously) set Q=SEED and wrap=0, independent of clk.
REQ-018 While reset is held high, SHALL hold Q=SEED and wrap=0 across clock edges.
REQ-019 Reset asserted mid-sequence SHALL discard the current state; after release, the first rising edge SHALL load the successor of SEED.

Configuration
REQ-020 Macro LFSR_LOCKUP_RECOVER_EN, when defined, SHALL add lockup recovery:
- If Q equals all-ones (e.g. after an upset or a forced value), the next edge SHALL load SEED instead of the XNOR successor.
- wrap SHALL stay 0 for that recovery transition.
REQ-021 Without LFSR_LOCKUP_RECOVER_EN, all-ones SHALL persist, since its XNOR successor is itself; no recovery logic SHALL be synthesized.

Structure
REQ-022 SHALL place the tap table (per-WIDTH tap masks) and constants MIN_WIDTH=3 and MAX_WIDTH=16 in shared package lfsr_pkg.
REQ-023 SHALL place the feedback-computation function in lfsr_pkg.
REQ-024 SHALL use one natural sub-module, lfsr_feedback: a combinational tap-mask XNOR reduce, instantiated once by lfsr.

Verification
REQ-025 Default instance: reset=1 for 2 edges, then 0 for 6 edges -> Q follows 000, 001, 011, 110, 101, 010, 100.
REQ-026 Continue to edge 7 after release -> Q=000 and wrap=1 for exactly one cycle; wrap=0 on every other cycle.
REQ-027 Reset reasserted mid-sequence at Q=110, between clock edges -> Q=000 immediately, before the next edge; Q holds 000 for 2 further edges.
REQ-028 Q forced to 111, then released:
- With LFSR_LOCKUP_RECOVER_EN -> Q=000 next edge, wrap=0.
- Without the macro -> Q stays 111 for 4 edges.
REQ-029 WIDTH=8, SEED=8'h01 -> the first return to 8'h01 occurs after exactly 255 edges, all visited states are distinct, and 8'hFF never appears.
REQ-030 Illegal configurations WIDTH=2, WIDTH=17, or WIDTH=3 with SEED=3'b111 -> elaboration fails.
